// File: rtl/hazard_ctrl.sv
// Load-use stall / branch-redirect flush controller with parameterizable bubble and flush lengths.
// Optional HAZARD_PERF_EN adds free-running stall_cnt / flush_cnt performance counters.
module hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       EX_BranchTaken,
    input  logic       EX_Jump,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_flush,
    output logic       ctrflush,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        REDIRECT   = 2'd2,
        ILLEGAL    = 2'd3
    } state_e;

    // The first bubble/flush cycle is issued from IDLE, so the counter covers the remainder.
    localparam logic [3:0] LB_INIT = (LOAD_BUBBLES > 1) ? 4'(LOAD_BUBBLES - 2) : 4'd0;
    localparam logic [3:0] FC_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       redirect, lu;
    logic       pc_w, ifid_w, ifid_fl, ctr_fl;

    assign redirect = EX_BranchTaken | EX_Jump;
    assign lu = EX_MemRead & (EX_rt != 5'd0) &
                ((ID_UseRs & (EX_rt == ID_rs)) | (ID_UseRt & (EX_rt == ID_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_fl = 1'b0;
        ctr_fl  = 1'b0;
        unique case (state_q)
            LOAD_STALL: begin
                if (redirect) begin
                    ifid_fl = 1'b1;
                    ctr_fl  = 1'b1;
                    state_d = (FLUSH_CYCLES > 1) ? REDIRECT : IDLE;
                    cnt_d   = FC_INIT;
                end else begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    ctr_fl = 1'b1;
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                ifid_fl = 1'b1;
                ctr_fl  = 1'b1;
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                // IDLE, and the unused encoding recovers through here.
                state_d = IDLE;
                if (redirect) begin
                    ifid_fl = 1'b1;
                    ctr_fl  = 1'b1;
                    state_d = (FLUSH_CYCLES > 1) ? REDIRECT : IDLE;
                    cnt_d   = FC_INIT;
                end else if (lu) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    ctr_fl = 1'b1;
                    state_d = (LOAD_BUBBLES > 1) ? LOAD_STALL : IDLE;
                    cnt_d   = LB_INIT;
                end
            end
        endcase
    end

    // Outputs are forced to a safe hold/flush pattern for as long as reset is asserted.
    assign PC_Write   = rst_n & pc_w;
    assign IFID_Write = rst_n & ifid_w;
    assign IFID_flush = ~rst_n | ifid_fl;
    assign ctrflush   = ~rst_n | ctr_fl;
    assign state_o    = rst_n ? state_q : 2'd0;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!PC_Write && !IFID_flush) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IFID_flush)               flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LB=1/FC=1 and LB=3/FC=2) on shared inputs, a vector table,
// hand-written multi-cycle sequences and random stimulus against a remaining-cycles model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
    logic       ID_UseRs = 0, ID_UseRt = 0, EX_MemRead = 0, EX_BranchTaken = 0, EX_Jump = 0;

    logic       pc0, ifw0, fl0, ctr0, pc1, ifw1, fl1, ctr1;
    logic [1:0] st0, st1;
`ifdef HAZARD_PERF_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_BUBBLES(1), .FLUSH_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
        .ID_UseRt(ID_UseRt), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .EX_BranchTaken(EX_BranchTaken), .EX_Jump(EX_Jump), .PC_Write(pc0),
        .IFID_Write(ifw0), .IFID_flush(fl0), .ctrflush(ctr0),
`ifdef HAZARD_PERF_EN
        .stall_cnt(sc0), .flush_cnt(fc0),
`endif
        .state_o(st0));

    hazard_ctrl #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
        .ID_UseRt(ID_UseRt), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .EX_BranchTaken(EX_BranchTaken), .EX_Jump(EX_Jump), .PC_Write(pc1),
        .IFID_Write(ifw1), .IFID_flush(fl1), .ctrflush(ctr1),
`ifdef HAZARD_PERF_EN
        .stall_cnt(sc1), .flush_cnt(fc1),
`endif
        .state_o(st1));

    // Reference model: cycles still owed to a stall or a flush after the current one.
    int          LB[2] = '{1, 3};
    int          FC[2] = '{1, 2};
    int          rem_s[2] = '{0, 0};
    int          rem_f[2] = '{0, 0};
    logic [31:0] m_sc[2] = '{0, 0};
    logic [31:0] m_fc[2] = '{0, 0};

    function automatic logic m_lu();
        return EX_MemRead && EX_rt != 0 &&
               ((ID_UseRs && EX_rt == ID_rs) || (ID_UseRt && EX_rt == ID_rt));
    endfunction

    // Expected {PC_Write, IFID_Write, IFID_flush, ctrflush} and state for instance k right now.
    task automatic m_out(input int k, output logic [3:0] o, output logic [1:0] st);
        logic redir;
        redir = EX_BranchTaken || EX_Jump;
        st = (rem_f[k] > 0) ? 2'd2 : (rem_s[k] > 0) ? 2'd1 : 2'd0;
        if (!rst_n)                         begin o = 4'b0011; st = 2'd0; end
        else if (rem_f[k] > 0 || redir)     o = 4'b1111;
        else if (rem_s[k] > 0 || m_lu())    o = 4'b0001;
        else                                o = 4'b1100;
    endtask

    task automatic m_step(input int k);
        logic [3:0] o;
        logic [1:0] st;
        if (!rst_n) begin
            rem_s[k] = 0; rem_f[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            return;
        end
        m_out(k, o, st);
        if (!o[3] && !o[1]) m_sc[k] = m_sc[k] + 1;
        if (o[1])           m_fc[k] = m_fc[k] + 1;
        if (rem_f[k] > 0)                         rem_f[k]--;
        else if (EX_BranchTaken || EX_Jump)       begin rem_f[k] = FC[k] - 1; rem_s[k] = 0; end
        else if (rem_s[k] > 0)                    rem_s[k]--;
        else if (m_lu())                          rem_s[k] = LB[k] - 1;
    endtask

    task automatic tick();
        m_step(0);
        m_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urs, input logic urt,
                         input logic bt, input logic j);
        EX_MemRead = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt;
        ID_UseRs = urs; ID_UseRt = urt; EX_BranchTaken = bt; EX_Jump = j;
    endtask

    task automatic chk_model(input string nm);
        logic [3:0] o;
        logic [1:0] st;
        m_out(0, o, st);
        chk({nm, "_u0_out"}, {28'd0, pc0, ifw0, fl0, ctr0}, {28'd0, o});
        chk({nm, "_u0_st"}, {30'd0, st0}, {30'd0, st});
        m_out(1, o, st);
        chk({nm, "_u1_out"}, {28'd0, pc1, ifw1, fl1, ctr1}, {28'd0, o});
        chk({nm, "_u1_st"}, {30'd0, st1}, {30'd0, st});
`ifdef HAZARD_PERF_EN
        chk({nm, "_u0_stallcnt"}, sc0, m_sc[0]);
        chk({nm, "_u0_flushcnt"}, fc0, m_fc[0]);
        chk({nm, "_u1_stallcnt"}, sc1, m_sc[1]);
        chk({nm, "_u1_flushcnt"}, fc1, m_fc[1]);
`endif
    endtask

    task automatic reset_pulse();
        #2 rst_n = 0;
        tick();
        #2 rst_n = 1;
    endtask

    typedef struct {
        logic       mr, urs, urt, bt, j;
        logic [4:0] ert, rs, rt;
        logic [3:0] exp;   // {PC_Write, IFID_Write, IFID_flush, ctrflush}
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{mr:1, urs:1, urt:0, bt:0, j:0, ert:8, rs:8, rt:0, exp:4'b0001};  // lu via rs
        vt[1] = '{mr:0, urs:1, urt:0, bt:0, j:0, ert:8, rs:8, rt:0, exp:4'b1100};  // not a load
        vt[2] = '{mr:1, urs:1, urt:1, bt:0, j:0, ert:0, rs:0, rt:0, exp:4'b1100};  // $0 masked
        vt[3] = '{mr:1, urs:0, urt:0, bt:0, j:0, ert:9, rs:0, rt:9, exp:4'b1100};  // rt not used
        vt[4] = '{mr:1, urs:0, urt:1, bt:0, j:0, ert:9, rs:0, rt:9, exp:4'b0001};  // lu via rt
        vt[5] = '{mr:1, urs:1, urt:0, bt:1, j:0, ert:8, rs:8, rt:0, exp:4'b1111};  // redirect wins
        vt[6] = '{mr:0, urs:0, urt:0, bt:0, j:1, ert:3, rs:3, rt:3, exp:4'b1111};  // jump
        vt[7] = '{mr:1, urs:0, urt:1, bt:0, j:0, ert:8, rs:8, rt:2, exp:4'b1100};  // rs match unused
        vt[8] = '{mr:1, urs:1, urt:1, bt:0, j:0, ert:5, rs:4, rt:6, exp:4'b1100};  // no match
        vt[9] = '{mr:1, urs:1, urt:1, bt:0, j:0, ert:31, rs:31, rt:31, exp:4'b0001};

        // Reset state
        #3;
        chk("reset_out", {28'd0, pc0, ifw0, fl0, ctr0}, 32'b0011);
        chk("reset_st", {30'd0, st0}, 32'd0);
        tick();
        #6 rst_n = 1;   // released between edges; next edge evaluates from IDLE
        #1;
        chk("post_reset_out", {28'd0, pc0, ifw0, fl0, ctr0}, 32'b1100);

        // Vector table on the single-cycle instance
        foreach (vt[i]) begin
            drive(vt[i].mr, vt[i].ert, vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].bt, vt[i].j);
            #1;
            chk($sformatf("vec%0d_out", i), {28'd0, pc0, ifw0, fl0, ctr0}, {28'd0, vt[i].exp});
            tick();
            chk($sformatf("vec%0d_st", i), {30'd0, st0}, 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("vec_idle_after", {28'd0, pc0, ifw0, fl0, ctr0}, 32'b1100);
        reset_pulse();

        // LOAD_BUBBLES=3: PC_Write low exactly 3 cycles, state 0,1,1,0
        begin
            logic [3:0] exp_pc;
            logic [7:0] exp_st;
            exp_pc = 4'b1000;
            exp_st = 8'b00_01_01_00;
            drive(1, 8, 8, 0, 1, 0, 0, 0);
            for (int c = 0; c < 4; c++) begin
                #1;
                chk($sformatf("lb3_pc_c%0d", c), {31'd0, pc1}, {31'd0, exp_pc[c]});
                chk($sformatf("lb3_st_c%0d", c), {30'd0, st1}, {30'd0, exp_st[2*c +: 2]});
                tick();
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            end
        end

        // FLUSH_CYCLES=2: IFID_flush high exactly 2 cycles
        begin
            logic [2:0] exp_fl;
            exp_fl = 3'b011;
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            for (int c = 0; c < 3; c++) begin
                #1;
                chk($sformatf("fc2_flush_c%0d", c), {31'd0, fl1}, {31'd0, exp_fl[c]});
                tick();
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            end
        end

        // Reset in the 2nd stall cycle aborts at once
        drive(1, 8, 8, 0, 1, 0, 0, 0);
        #1 tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("mid_stall_st", {30'd0, st1}, 32'd1);
        #1 rst_n = 0;
        #1 chk("async_rst_out", {28'd0, pc1, ifw1, fl1, ctr1}, 32'b0011);
        chk("async_rst_st", {30'd0, st1}, 32'd0);
        tick();
        #2 rst_n = 1;
        tick();
        chk("after_rst_out", {28'd0, pc1, ifw1, fl1, ctr1}, 32'b1100);
        chk("after_rst_st", {30'd0, st1}, 32'd0);

        // Random stimulus against the model
        reset_pulse();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
            #1 chk_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 0;
                #1 chk_model($sformatf("rnd%0d_rst", n));
                tick();
                #2 rst_n = 1;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
